// File: rtl/cdb_arbiter_pkg.sv
// rtl/cdb_arbiter_pkg.sv - CDB lane/entry types and sizing shared with ro_buffer and reservation stations
`ifndef NUM_CDB_ENTRIES
`define NUM_CDB_ENTRIES 2
`endif
`ifndef RO_BUFFER_ENTRIES
`define RO_BUFFER_ENTRIES 16
`endif

package cdb_arbiter_pkg;

  localparam int NUM_LANES = `NUM_CDB_ENTRIES;
  localparam int TAG_W     = $clog2(`RO_BUFFER_ENTRIES);
  localparam int VALUE_W   = 32;

  typedef logic [TAG_W-1:0] rob_tag_t;

  typedef struct packed {
    logic                valid;
    rob_tag_t            tag;
    logic [VALUE_W-1:0]  value;
  } cdb_entry_t;

  typedef cdb_entry_t [NUM_LANES-1:0] cdb_t;

  // FIFO payload: valid is implied by occupancy, so it is not stored
  typedef struct packed {
    rob_tag_t            tag;
    logic [VALUE_W-1:0]  value;
  } src_entry_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// rtl/cdb_arbiter_if.sv - producer handshake bundle and CDB broadcast lanes
interface cdb_arbiter_if #(
  parameter int NUM_SRC = 4
);
  import cdb_arbiter_pkg::*;

  logic [NUM_SRC-1:0]              src_valid;
  rob_tag_t [NUM_SRC-1:0]          src_tag;
  logic [NUM_SRC-1:0][VALUE_W-1:0] src_value;
  logic [NUM_SRC-1:0]              src_ready;
  cdb_t                            cdb;

  modport master (
    output src_valid, src_tag, src_value,
    input  src_ready, cdb
  );

  modport slave (
    input  src_valid, src_tag, src_value,
    output src_ready, cdb
  );

endinterface

// File: rtl/cdb_src_fifo.sv
// rtl/cdb_src_fifo.sv - per-producer result queue; flush beats push/pop, ready derives from registered count
module cdb_src_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_flush,
  input  logic       i_push,
  input  src_entry_t i_din,
  input  logic       i_pop,
  output src_entry_t o_dout,
  output logic       o_empty,
  output logic       o_full
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  src_entry_t       r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_do_push;
  logic w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_dout    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full && !i_flush;
  assign w_do_pop  = i_pop && !o_empty && !i_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: occupancy alone decides what is readable
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - CDB transmit side: per-source FIFOs, round-robin grant of NUM_LANES registered lanes
// Optional: CDB_BYPASS_EN lets an empty source compete with its live input (1-edge latency).
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_SRC    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_flush,
  cdb_arbiter_if.slave bus
);

  localparam int PTR_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int LANE_W = $clog2(NUM_LANES + 1);

  src_entry_t        w_din  [NUM_SRC];
  src_entry_t        w_head [NUM_SRC];
  src_entry_t        w_sel  [NUM_SRC];
  logic [LANE_W-1:0] w_rank [NUM_SRC];

  logic [NUM_SRC-1:0] w_empty;
  logic [NUM_SRC-1:0] w_full;
  logic [NUM_SRC-1:0] w_live;
  logic [NUM_SRC-1:0] w_cand;
  logic [NUM_SRC-1:0] w_grant;
  logic [NUM_SRC-1:0] w_push;
  logic [NUM_SRC-1:0] w_pop;

  logic [PTR_W-1:0] r_rr_ptr;
  logic [PTR_W-1:0] w_rr_next;
  cdb_t             r_cdb;
  cdb_t             w_cdb;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    assign w_din[g]  = '{tag: bus.src_tag[g], value: bus.src_value[g]};
    // Tag 0 consumes the handshake but never reaches a FIFO or the bus
    assign w_live[g] = bus.src_valid[g] && !w_full[g] && (bus.src_tag[g] != '0) && !i_flush;
`ifdef CDB_BYPASS_EN
    assign w_sel[g]  = w_empty[g] ? w_din[g] : w_head[g];
`else
    assign w_sel[g]  = w_head[g];
`endif

    cdb_src_fifo #(
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_flush (i_flush),
      .i_push  (w_push[g]),
      .i_din   (w_din[g]),
      .i_pop   (w_pop[g]),
      .o_dout  (w_head[g]),
      .o_empty (w_empty[g]),
      .o_full  (w_full[g])
    );
  end

`ifdef CDB_BYPASS_EN
  assign w_cand = ~w_empty | (w_empty & w_live);
  assign w_push = w_live & ~(w_grant & w_empty);
`else
  assign w_cand = ~w_empty;
  assign w_push = w_live;
`endif
  assign w_pop = w_grant & ~w_empty;

  always_comb begin
    logic [LANE_W-1:0] n_won;
    logic [PTR_W-1:0]  idx;
    n_won     = '0;
    idx       = '0;
    w_grant   = '0;
    w_rr_next = r_rr_ptr;
    for (int i = 0; i < NUM_SRC; i++) w_rank[i] = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = PTR_W'((int'(r_rr_ptr) + k) % NUM_SRC);
      if (w_cand[idx] && (int'(n_won) < NUM_LANES)) begin
        w_grant[idx] = 1'b1;
        w_rank[idx]  = n_won;
        n_won        = n_won + LANE_W'(1);
        w_rr_next    = PTR_W'((int'(idx) + 1) % NUM_SRC);
      end
    end
  end

  // Lane k carries the k-th winner in scan order
  always_comb begin
    w_cdb = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (w_grant[i] && (int'(w_rank[i]) == l)) begin
          w_cdb[l].valid = 1'b1;
          w_cdb[l].tag   = w_sel[i].tag;
          w_cdb[l].value = w_sel[i].value;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cdb    <= '0;
      r_rr_ptr <= '0;
    end else if (i_flush) begin
      r_cdb    <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_cdb    <= w_cdb;
      r_rr_ptr <= w_rr_next;
    end
  end

  assign bus.src_ready = ~w_full;
  assign bus.cdb       = r_cdb;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed vector bench for cdb_arbiter (4 sources, 2 lanes, depth 4)
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int NSRC = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;

  always #5 clk = ~clk;

  cdb_arbiter_if #(.NUM_SRC(NSRC)) bus ();

  cdb_arbiter #(
    .NUM_SRC    (NSRC),
    .FIFO_DEPTH (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (flush),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        flush;
    logic [3:0]  valid;
    rob_tag_t    tag   [4];
    logic [31:0] value [4];
    logic [3:0]  ready;
    rob_tag_t    etag  [2];
    logic [31:0] evalue[2];
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] lane_exp(input rob_tag_t t, input logic [31:0] v);
    cdb_entry_t e;
    e.valid = (t != '0);
    e.tag   = t;
    e.value = (t != '0) ? v : 32'h0;
    return 64'(e);
  endfunction

  function automatic logic [31:0] fv(input int src, input int seq);
    return {16'(src), 16'(seq)};
  endfunction

  function automatic vec_t mk(input logic fl, input logic [3:0] val, input logic [3:0] rdy,
                              input int t0, input logic [31:0] v0,
                              input int t1, input logic [31:0] v1);
    vec_t v;
    v.flush = fl;
    v.valid = val;
    for (int i = 0; i < 4; i++) begin
      v.tag[i]   = '0;
      v.value[i] = '0;
    end
    v.ready     = rdy;
    v.etag[0]   = rob_tag_t'(t0);
    v.evalue[0] = v0;
    v.etag[1]   = rob_tag_t'(t1);
    v.evalue[1] = v1;
    return v;
  endfunction

  function automatic vec_t with_src(input vec_t v, input int i, input int t, input logic [31:0] val);
    vec_t r = v;
    r.tag[i]   = rob_tag_t'(t);
    r.value[i] = val;
    return r;
  endfunction

  // All four sources valid; source i always uses tag i+1 and value {i, seq}
  task automatic fair(input logic [3:0] rdy, input int s0, input int s1, input int s2, input int s3,
                      input int a_src, input int a_seq, input int b_src, input int b_seq);
    vec_t v;
    int s[4];
    s = '{s0, s1, s2, s3};
    v = mk(1'b0, 4'hF, rdy,
           (a_src >= 0) ? a_src + 1 : 0, (a_src >= 0) ? fv(a_src, a_seq) : 32'h0,
           (b_src >= 0) ? b_src + 1 : 0, (b_src >= 0) ? fv(b_src, b_seq) : 32'h0);
    for (int i = 0; i < 4; i++) v = with_src(v, i, i + 1, fv(i, s[i]));
    vecs.push_back(v);
  endtask

  task automatic drive(input logic fl, input logic [3:0] val);
    flush         = fl;
    bus.src_valid = val;
  endtask

  task automatic check_idle_bus(input string name);
    check({name, " lane0"}, 64'(bus.cdb[0]), 64'h0);
    check({name, " lane1"}, 64'(bus.cdb[1]), 64'h0);
  endtask

  task automatic build_table();
    vec_t v;
    fair(4'hF, 1, 1, 1, 1, -1, 0, -1, 0);
    fair(4'hF, 2, 2, 2, 2,  0, 1,  1, 1);
    fair(4'hF, 3, 3, 3, 3,  2, 1,  3, 1);
    fair(4'hF, 4, 4, 4, 4,  0, 2,  1, 2);
    fair(4'hF, 5, 5, 5, 5,  2, 2,  3, 2);
    fair(4'b0011, 6, 6, 6, 6, 0, 3, 1, 3);
    fair(4'b1100, 7, 7, 7, 7, 2, 3, 3, 3);
    fair(4'b0011, 8, 8, 7, 7, 0, 4, 1, 4);
    fair(4'b1100, 8, 8, 8, 8, 2, 4, 3, 4);
    fair(4'b0011, 9, 9, 8, 8, 0, 5, 1, 5);
    v = with_src(mk(1'b1, 4'b0010, 4'hF, 0, 0, 0, 0), 1, 9, 32'h0000_0BAD);
    vecs.push_back(v);
    vecs.push_back(mk(1'b0, 4'h0, 4'hF, 0, 0, 0, 0));
    vecs.push_back(mk(1'b0, 4'h0, 4'hF, 0, 0, 0, 0));
    // rr_ptr must restart at 0 after flush: src1 on lane0, src3 on lane1
    v = mk(1'b0, 4'b1010, 4'hF, 0, 0, 0, 0);
    v = with_src(v, 1, 8, 32'h0000_0088);
    v = with_src(v, 3, 7, 32'h0000_0077);
    vecs.push_back(v);
    vecs.push_back(mk(1'b0, 4'h0, 4'hF, 8, 32'h0000_0088, 7, 32'h0000_0077));
    vecs.push_back(mk(1'b0, 4'h0, 4'hF, 0, 0, 0, 0));
    vecs.push_back(with_src(mk(1'b0, 4'b0001, 4'hF, 0, 0, 0, 0), 0, 5, 32'hDEAD_BEEF));
    vecs.push_back(mk(1'b0, 4'h0, 4'hF, 5, 32'hDEAD_BEEF, 0, 0));
    vecs.push_back(mk(1'b0, 4'h0, 4'hF, 0, 0, 0, 0));
    vecs.push_back(with_src(mk(1'b0, 4'b0010, 4'hF, 0, 0, 0, 0), 1, 0, 32'h0000_0123));
    vecs.push_back(mk(1'b0, 4'h0, 4'hF, 0, 0, 0, 0));
    // rr_ptr is 1 here, so src2/src3 win ahead of src0
    v = mk(1'b0, 4'b1101, 4'hF, 0, 0, 0, 0);
    v = with_src(v, 0, 3, 32'h0000_0030);
    v = with_src(v, 2, 4, 32'h0000_0040);
    v = with_src(v, 3, 6, 32'h0000_0060);
    vecs.push_back(v);
    vecs.push_back(mk(1'b0, 4'h0, 4'hF, 4, 32'h0000_0040, 6, 32'h0000_0060));
    vecs.push_back(mk(1'b0, 4'h0, 4'hF, 3, 32'h0000_0030, 0, 0));
    vecs.push_back(mk(1'b0, 4'h0, 4'hF, 0, 0, 0, 0));
  endtask

  task automatic run_table();
    foreach (vecs[r]) begin
      drive(vecs[r].flush, vecs[r].valid);
      for (int i = 0; i < 4; i++) begin
        bus.src_tag[i]   = vecs[r].tag[i];
        bus.src_value[i] = vecs[r].value[i];
      end
      @(posedge clk);
      #1;
      check($sformatf("row%0d ready", r), 64'(bus.src_ready), 64'(vecs[r].ready));
      check($sformatf("row%0d lane0", r), 64'(bus.cdb[0]), lane_exp(vecs[r].etag[0], vecs[r].evalue[0]));
      check($sformatf("row%0d lane1", r), 64'(bus.cdb[1]), lane_exp(vecs[r].etag[1], vecs[r].evalue[1]));
    end
    drive(1'b0, 4'h0);
  endtask

  task automatic run_reset_midstream();
    drive(1'b0, 4'hF);
    for (int i = 0; i < 4; i++) begin
      bus.src_tag[i]   = rob_tag_t'(i + 1);
      bus.src_value[i] = fv(i, 1);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) bus.src_value[i] = fv(i, 2);
    @(posedge clk);
    #1;
    check("pre-reset lane0", 64'(bus.cdb[0]), lane_exp(1, fv(0, 1)));
    check("pre-reset lane1", 64'(bus.cdb[1]), lane_exp(2, fv(1, 1)));
    drive(1'b0, 4'h0);
    #3;
    rst_n = 1'b0;
    #1;
    check_idle_bus("async reset");
    check("async reset ready", 64'(bus.src_ready), 64'hF);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check_idle_bus($sformatf("post-reset c%0d", c));
    end
  endtask

  task automatic run_bypass();
    drive(1'b0, 4'b1000);
    bus.src_tag[3]   = rob_tag_t'(7);
    bus.src_value[3] = 32'h0000_0077;
    @(posedge clk);
    #1;
    check("bypass lane0", 64'(bus.cdb[0]), lane_exp(7, 32'h0000_0077));
    check("bypass lane1", 64'(bus.cdb[1]), 64'h0);
    check("bypass ready", 64'(bus.src_ready), 64'hF);
    drive(1'b0, 4'b0001);
    bus.src_tag[0]   = '0;
    bus.src_value[0] = 32'h0000_0055;
    @(posedge clk);
    #1;
    check_idle_bus("bypass tag0");
    drive(1'b0, 4'h0);
    @(posedge clk);
    #1;
    check_idle_bus("bypass drained");
  endtask

  initial begin
    rst_n         = 1'b0;
    flush         = 1'b0;
    bus.src_valid = '0;
    bus.src_tag   = '0;
    bus.src_value = '0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_bus("reset");
    check("reset ready", 64'(bus.src_ready), 64'hF);
    rst_n = 1'b1;
`ifdef CDB_BYPASS_EN
    run_bypass();
`else
    run_reset_midstream();
    build_table();
    run_table();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", n_checks);
    $fatal(1);
  end

endmodule
